// File: rtl/keystream_xor_unit.sv
// -----------------------------------------------------------------------------
// keystream_xor_unit
//
// Stream cipher combiner: XORs 128-bit data beats with 128-bit lanes taken
// from a 512-bit keystream block. AES blocks carry a single lane (bits
// [127:0]); ChaCha blocks carry four lanes, consumed low lane first. When a
// block runs out mid-message, the next block is requested. A beat flagged
// last ends the message and drops any unused lanes.
//
// Ports
//   clk_i                    clock, rising edge
//   rst_ni                   asynchronous reset, active low
//   algo_sel_i               0 = AES, 1 = ChaCha; latched on start_i
//   start_i                  one-cycle pulse, begins (or restarts) a message
//   ks_req_o                 one-cycle keystream block request
//   ks_valid_i, ks_data_i    keystream block delivery (512 bits)
//   in_valid_i/in_ready_o    input beat handshake
//   in_data_i/keep_i/last_i  input beat: data, byte enables, final flag
//   out_valid_o/out_ready_i  output beat handshake
//   out_data_o/keep_o/last_o XORed beat, forwarded keep/last
//   busy_o                   message in progress or final beat not yet drained
// -----------------------------------------------------------------------------

// Single byte lane of the combiner: disabled bytes are forced to zero.
module ksx_byte (
    input  logic [7:0] d_i,
    input  logic [7:0] ks_i,
    input  logic       keep_i,
    output logic [7:0] q_o
);
    assign q_o = keep_i ? (d_i ^ ks_i) : 8'h00;
endmodule

module keystream_xor_unit (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         algo_sel_i,
    input  logic         start_i,
    output logic         ks_req_o,
    input  logic         ks_valid_i,
    input  logic [511:0] ks_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    input  logic [15:0]  in_keep_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic [15:0]  out_keep_o,
    output logic         out_last_o,
    output logic         busy_o
);

    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT_KS = 2'd2,
        S_XOR     = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic           algo_q;
    logic [511:0]   buf_q;
    logic [1:0]     lane_idx_q;
    logic [2:0]     lanes_left_q;

    logic           out_valid_q;
    logic [127:0]   out_data_q;
    logic [15:0]    out_keep_q;
    logic           out_last_q;

    logic           accept;
    logic           ks_take;
    logic           abort;
    logic [127:0]   lane;
    logic [127:0]   xored;

    // ------------------------------------------------------------------
    // Handshake qualifiers. A start pulse overrides everything else in the
    // same cycle: in_ready is masked so no beat slips in, and a keystream
    // block arriving alongside it is ignored.
    // ------------------------------------------------------------------
    assign accept  = in_valid_i && in_ready_o;
    assign ks_take = (state_q == S_WAIT_KS) && ks_valid_i && !start_i;
    assign abort   = start_i && (state_q != S_IDLE);

    // Current lane out of the buffered keystream block.
    always_comb begin
        lane = buf_q[127:0];
        case (lane_idx_q)
            2'd0: lane = buf_q[127:0];
            2'd1: lane = buf_q[255:128];
            2'd2: lane = buf_q[383:256];
            2'd3: lane = buf_q[511:384];
            default: lane = buf_q[127:0];
        endcase
    end

    // Byte-wise XOR with keep masking.
    for (genvar b = 0; b < NUM_BYTES; b++) begin : g_byte
        ksx_byte u_byte (
            .d_i    (in_data_i[8*b +: 8]),
            .ks_i   (lane[8*b +: 8]),
            .keep_i (in_keep_i[b]),
            .q_o    (xored[8*b +: 8])
        );
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = S_REQ;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_REQ:     state_d = S_WAIT_KS;
                S_WAIT_KS: if (ks_valid_i) state_d = S_XOR;
                S_XOR: begin
                    if (accept) begin
                        if (in_last_i)                state_d = S_IDLE;
                        else if (lanes_left_q == 3'd1) state_d = S_REQ;
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ks_req_o   = (state_q == S_REQ);
        // Input may only advance when the output register is free or
        // draining this cycle, so there is never more than one beat in flight.
        in_ready_o = (state_q == S_XOR) && (!out_valid_q || out_ready_i) && !start_i;
        busy_o     = (state_q != S_IDLE) || out_valid_q;
    end

    // ------------------------------------------------------------------
    // Keystream buffer and lane bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            algo_q       <= 1'b0;
            buf_q        <= '0;
            lane_idx_q   <= 2'd0;
            lanes_left_q <= 3'd0;
        end else if (start_i) begin
            // New message: relatch algorithm and drop any leftover keystream.
            algo_q       <= algo_sel_i;
            buf_q        <= '0;
            lane_idx_q   <= 2'd0;
            lanes_left_q <= 3'd0;
        end else if (ks_take) begin
            buf_q        <= ks_data_i;
            lane_idx_q   <= 2'd0;
            lanes_left_q <= algo_q ? 3'd4 : 3'd1;
        end else if (accept) begin
            lane_idx_q   <= lane_idx_q + 2'd1;
            // A last beat discards whatever lanes remain in the block.
            lanes_left_q <= in_last_i ? 3'd0 : (lanes_left_q - 3'd1);
        end
    end

    // ------------------------------------------------------------------
    // Output register. Reloads on accept even while draining, so a stream
    // with out_ready held high runs at one beat per cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (abort) begin
            // Restart mid-message drops the in-flight beat.
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= xored;
            out_keep_q  <= in_keep_i;
            out_last_q  <= in_last_i;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_keep_o  = out_keep_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_keystream_xor_unit.sv
module tb_keystream_xor_unit;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         algo_sel = 1'b0, start = 1'b0, ks_valid = 1'b0;
    logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [511:0] ks_data = '0;
    logic [127:0] in_data = '0;
    logic [15:0]  in_keep = '0;
    logic         ks_req, in_ready, out_valid, out_last, busy;
    logic [127:0] out_data;
    logic [15:0]  out_keep;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    logic [127:0] lanes[$];      // model: keystream lanes available, in order
    beat_t        expq[$];       // model: expected output beats
    logic [511:0] ks_src_q[$];   // directed keystream blocks (else random)
    beat_t        in_src_q[$];   // directed input beats (else random)

    always #5 clk = ~clk;

    keystream_xor_unit dut (
        .clk_i(clk), .rst_ni(rst_n), .algo_sel_i(algo_sel), .start_i(start),
        .ks_req_o(ks_req), .ks_valid_i(ks_valid), .ks_data_i(ks_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .in_keep_i(in_keep), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_keep_o(out_keep), .out_last_o(out_last), .busy_o(busy)
    );

    function automatic logic [127:0] xor_ref(input logic [127:0] d, input logic [127:0] ln,
                                             input logic [15:0] k);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (k[i]) r[8*i +: 8] = d[8*i +: 8] ^ ln[8*i +: 8];
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // A block yields one lane for AES, four for ChaCha (low lane first).
    task automatic model_block(input bit algo, input logic [511:0] b);
        if (algo) for (int k = 0; k < 4; k++) lanes.push_back(b[128*k +: 128]);
        else      lanes.push_back(b[127:0]);
    endtask

    // Full message with a reactive keystream source, random stalls and
    // stray ks_valid pulses outside WAIT_KS.
    task automatic run_msg(input bit algo, input int n, input int rdy_pct);
        int sent = 0, loaded = 0, got = 0, nreq = 0, cyc = 0, dly = 0, exp_req;
        bit pend = 0, acc = 0, chk = 0;
        beat_t chk_b, nb, e;
        logic [511:0] b;
        logic [127:0] ln;
        lanes.delete();
        expq.delete();
        @(negedge clk);
        start = 1'b1; algo_sel = algo; in_valid = 1'b0; ks_valid = 1'b0; out_ready = 1'b1;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            start = 1'b0;
            if (acc) in_valid = 1'b0;
            acc = 0;
            ks_valid = 1'b0;
            if (ks_req) begin
                nreq++; pend = 1; dly = $urandom_range(0, 3);
            end else if (pend) begin
                if (dly == 0) begin
                    b = (ks_src_q.size() != 0) ? ks_src_q.pop_front() : rnd512();
                    ks_data = b; ks_valid = 1'b1; pend = 0;
                    model_block(algo, b);
                end else dly--;
            end else if ($urandom_range(0, 5) == 0) begin
                ks_data = rnd512(); ks_valid = 1'b1;
            end
            if (!in_valid && loaded < n && $urandom_range(0, 3) != 0) begin
                if (in_src_q.size() != 0) nb = in_src_q.pop_front();
                else begin
                    nb.d = rnd128();
                    case ($urandom_range(0, 3))
                        0: nb.k = 16'h0000;
                        1: nb.k = 16'hFFFF;
                        default: nb.k = 16'($urandom());
                    endcase
                end
                in_data = nb.d; in_keep = nb.k; in_last = (loaded == n - 1);
                in_valid = 1'b1; loaded++;
            end
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            #1;
            if (chk) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== chk_b.d || out_keep !== chk_b.k ||
                    out_last !== chk_b.l) begin
                    fails++;
                    $display("FAIL latency: valid=%b data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                             out_valid, out_data, out_keep, out_last, chk_b.d, chk_b.k, chk_b.l);
                end
                chk = 0;
            end
            if (out_valid && out_ready) begin
                tests++;
                if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL out_unexpected: data=%h exp none", out_data);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e.d || out_keep !== e.k || out_last !== e.l) begin
                        fails++;
                        $display("FAIL out_beat%0d: data=%h keep=%h last=%b exp data=%h keep=%h last=%b",
                                 got, out_data, out_keep, out_last, e.d, e.k, e.l);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                if (lanes.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL accept_no_ks: accepted beat %0d exp no accept", sent);
                    ln = '0;
                end else ln = lanes.pop_front();
                chk_b.d = xor_ref(in_data, ln, in_keep); chk_b.k = in_keep; chk_b.l = in_last;
                expq.push_back(chk_b);
                chk = 1; acc = 1; sent++;
                if (in_last) lanes.delete();
            end
            cyc++;
        end
        tests++;
        if (got < n) begin
            fails++;
            $display("FAIL msg_timeout: got %0d beats exp %0d", got, n);
        end
        exp_req = algo ? (n + 3) / 4 : n;
        tests++;
        if (nreq != exp_req) begin
            fails++;
            $display("FAIL ks_req_count: got %0d exp %0d", nreq, exp_req);
        end
        @(negedge clk);
        in_valid = 1'b0; ks_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || ks_req !== 1'b0) begin
            fails++;
            $display("FAIL msg_end: busy=%b out_valid=%b ks_req=%b exp 0 0 0", busy, out_valid, ks_req);
        end
    endtask

    // Start a message, hand over block b, return #1 after the edge that entered XOR.
    task automatic open_msg(input bit algo, input logic [511:0] b, output bit ok);
        int t;
        ok = 0;
        @(negedge clk);
        start = 1'b1; algo_sel = algo; ks_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!ks_req && t < 20) begin @(negedge clk); t++; end
        tests++;
        if (!ks_req) begin
            fails++;
            $display("FAIL open_ks_req: ks_req=%b exp 1", ks_req);
            return;
        end
        @(negedge clk);
        ks_data = b; ks_valid = 1'b1;
        @(negedge clk);
        ks_valid = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL open_in_ready: in_ready=%b exp 1", in_ready);
        end else ok = 1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({ks_req, out_valid, out_last, in_ready, busy} !== 5'b0 || out_data !== '0 || out_keep !== '0) begin
            fails++;
            $display("FAIL reset_state: req=%b ov=%b data=%h keep=%h last=%b ir=%b busy=%b exp all 0",
                     ks_req, out_valid, out_data, out_keep, out_last, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = rnd128(); in_keep = 16'hFFFF; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ks_valid = i[0]; ks_data = rnd512();
            #1;
            tests++;
            if (ks_req !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL idle_quiet: req=%b ir=%b busy=%b ov=%b exp 0 0 0 0", ks_req, in_ready, busy, out_valid);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; ks_valid = 1'b0;
    endtask

    task automatic test_aes_single();
        beat_t bt;
        ks_src_q.push_back({rnd128(), rnd128(), rnd128(), {16{8'hFF}}});
        bt.d = '0; bt.k = 16'hFFFF; bt.l = 1'b1;
        in_src_q.push_back(bt);
        run_msg(1'b0, 1, 100);
    endtask

    task automatic test_chacha_refill();
        beat_t bt;
        ks_src_q.push_back({128'h4, 128'h3, 128'h2, 128'h1});
        ks_src_q.push_back(rnd512());
        bt.d = '0; bt.k = 16'hFFFF; bt.l = 1'b0;
        for (int i = 0; i < 5; i++) in_src_q.push_back(bt);
        run_msg(1'b1, 5, 100);
    endtask

    task automatic test_keep();
        beat_t bt;
        ks_src_q.push_back({64{8'h55}});
        bt.d = {16{8'hAA}}; bt.k = 16'h00FF; bt.l = 1'b1;
        in_src_q.push_back(bt);
        run_msg(1'b1, 1, 100);
    endtask

    task automatic test_last_discard();
        run_msg(1'b1, 2, 100);
        run_msg(1'b1, 1, 100);
    endtask

    task automatic test_backpressure();
        logic [511:0] b;
        logic [127:0] d[4];
        logic [127:0] e[4];
        bit ok;
        b = rnd512();
        for (int i = 0; i < 4; i++) begin
            d[i] = rnd128();
            e[i] = xor_ref(d[i], b[128*i +: 128], 16'hFFFF);
        end
        open_msg(1'b1, b, ok);
        if (!ok) return;
        in_valid = 1'b1; in_data = d[0]; in_keep = 16'hFFFF; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_data = d[1];
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== e[0] || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall%0d: ov=%b data=%h ir=%b exp 1 %h 0", i, out_valid, out_data, in_ready, e[0]);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== e[i] || out_last !== (i == 3)) begin
                fails++;
                $display("FAIL b2b%0d: ov=%b data=%h last=%b exp 1 %h %b", i, out_valid, out_data, out_last, e[i], i == 3);
            end
            @(negedge clk);
            if (i < 2) begin in_data = d[i + 2]; in_last = (i == 1); end
            else in_valid = 1'b0;
        end
        #1;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: ov=%b busy=%b exp 0 0", out_valid, busy);
        end
        in_last = 1'b0;
    endtask

    task automatic test_abort();
        logic [511:0] b, b2;
        logic [127:0] d2, e2;
        bit ok;
        b = rnd512(); b2 = rnd512(); d2 = rnd128();
        e2 = xor_ref(d2, b2[127:0], 16'hFFFF);
        open_msg(1'b1, b, ok);
        if (!ok) return;
        in_valid = 1'b1; in_data = rnd128(); in_keep = 16'hFFFF; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; algo_sel = 1'b0; in_data = rnd128(); out_ready = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_mask: ov=%b ir=%b exp 1 0", out_valid, in_ready);
        end
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || ks_req !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_state: ov=%b req=%b busy=%b exp 0 1 1", out_valid, ks_req, busy);
        end
        @(negedge clk);
        ks_data = b2; ks_valid = 1'b1;
        @(negedge clk);
        ks_valid = 1'b0; in_valid = 1'b1; in_data = d2; in_last = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        // AES relatched: the single lane is spent, so a new block is requested.
        tests++;
        if (out_valid !== 1'b1 || out_data !== e2 || ks_req !== 1'b1) begin
            fails++;
            $display("FAIL abort_relatch: ov=%b data=%h req=%b exp 1 %h 1", out_valid, out_data, ks_req, e2);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        open_msg(1'b1, rnd512(), ok);
        if (!ok) return;
        in_valid = 1'b1; in_data = rnd128(); in_keep = 16'hFFFF; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ks_req, out_valid, out_last, in_ready, busy} !== 5'b0 || out_data !== '0 || out_keep !== '0) begin
            fails++;
            $display("FAIL async_reset: req=%b ov=%b data=%h keep=%h ir=%b busy=%b exp all 0",
                     ks_req, out_valid, out_data, out_keep, in_ready, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ks_valid = 1'b1; ks_data = rnd512(); in_valid = 1'b1;
            #1;
            tests++;
            if (ks_req !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_idle: req=%b ov=%b busy=%b exp 0 0 0", ks_req, out_valid, busy);
            end
            @(negedge clk);
        end
        ks_valid = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int m = 0; m < 25; m++)
            run_msg(1'($urandom_range(0, 1)), $urandom_range(1, 9), 30 + 35 * $urandom_range(0, 2));
    endtask

    initial begin
        test_reset();
        test_aes_single();
        test_chacha_refill();
        test_keep();
        test_backpressure();
        test_last_discard();
        test_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/keystream_xor_unit.md
KEYSTREAM_XOR_UNIT -- requirements
Module: keystream_xor_unit

Interface
REQ-001 No parameters; data width 128 bits, keystream width 512 bits, both fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 algo_sel  input  1  0=AES (one 128-bit lane per keystream block), 1=ChaCha (four lanes per block); sampled only on start.
REQ-005 start  input  1  one-cycle pulse; begins a new message and latches algo_sel.
REQ-006 ks_req  output  1  one-cycle request pulse to the keystream source.
REQ-007 ks_valid  input  1  keystream block present on ks_data.
REQ-008 ks_data  input  512  keystream block; AES uses bits [127:0] only.
REQ-009 in_valid / in_ready  input / output  1 / 1  plaintext/ciphertext beat handshake.
REQ-010 in_data, in_keep, in_last  input  128, 16, 1  beat data, byte enables (bit i = bytes [8i+7:8i]), final beat flag.
REQ-011 out_valid / out_ready  output / input  1 / 1  result beat handshake.
REQ-012 out_data, out_keep, out_last  output  128, 16, 1  XORed beat, forwarded keep, forwarded last.
REQ-013 busy  output  1  high from start until the last beat leaves the output register.

Function
REQ-014 FSM states: IDLE, REQ, WAIT_KS, XOR.
REQ-015 IDLE -> REQ on start; algo_r <= algo_sel.
REQ-016 REQ: ks_req=1 for exactly one cycle, unconditional transition to WAIT_KS.
REQ-017 WAIT_KS: on ks_valid, capture ks_data into a 512-bit buffer, set lane_idx=0, lanes_left=4 (ChaCha) or 1 (AES), go to XOR; ks_valid in any other state is ignored.
REQ-018 in_ready = (state==XOR) && (!out_valid || out_ready); a beat is accepted when in_valid && in_ready.
REQ-019 Lane k = buffer[128k+127:128k]; an accepted beat uses lane lane_idx, then lane_idx increments and lanes_left decrements.
REQ-020 out_data byte i = in_data byte i XOR lane byte i when in_keep[i]=1, else 8'h00; out_keep = in_keep; out_last = in_last.
REQ-021 Latency: out_valid asserts the cycle after acceptance; output register holds stable while out_valid && !out_ready.
REQ-022 out_valid clears on out_ready when no new beat is accepted in the same cycle; simultaneous drain and accept reloads the register without a bubble.
REQ-023 Accepted beat with in_last=1: remaining lanes discarded, state -> IDLE; busy falls when that beat is drained.
REQ-024 Accepted beat with in_last=0 and lanes_left reaching 0: state -> REQ (buffer exhausted; next block requested).
REQ-025 in_keep=16'h0000 still consumes one lane.
REQ-026 start while not IDLE: abort, out_valid cleared, buffer invalidated, algo re-latched, state -> REQ next cycle; in-flight output beat is dropped.
REQ-027 start in the same cycle as an input acceptance: start wins; the beat is not accepted (in_ready forced 0 when start=1).
REQ-028 At most one ks_req per keystream block; no ks_req while a buffer has lanes remaining.

Reset
REQ-029 rst_n low asynchronously forces state=IDLE, ks_req=0, out_valid=0, out_data=0, out_keep=0, out_last=0, in_ready=0, busy=0, lane_idx=0, lanes_left=0, algo_r=0, buffer=0.
REQ-030 Reset mid-message discards all buffered keystream and output; after release, no activity until start.

Verification
REQ-031 AES, start, ks_data[127:0]=all 8'hFF, one beat in_data=128'h0, keep=16'hFFFF, last=1 -> ks_req pulse once, out_data=all FF, out_last=1 one cycle after acceptance, busy low after drain.
REQ-032 ChaCha, ks_data lanes 0..3 = 128'h1/2/3/4, five beats of data 0, last on fifth -> outputs 1,2,3,4 then second ks_req, fifth output = lane 0 of new block; exactly two ks_req pulses.
REQ-033 ChaCha, keep=16'h00FF, in_data all 8'hAA, lane all 8'h55 -> out_data=128'h0000...00FF..FF (low 8 bytes FF, high 8 bytes 00), out_keep=16'h00FF.
REQ-034 out_ready held 0 for 5 cycles with out_valid=1 -> out_data stable, in_ready=0, no beat lost; release -> back-to-back beats at one per cycle.
REQ-035 ChaCha, last on second beat, then start -> lanes 2..3 discarded, new ks_req, first output uses lane 0 of new block.
REQ-036 rst_n asserted in XOR with out_valid=1 -> all outputs zero immediately (asynchronous), no ks_req after release until start.
